// File: rtl/calc_cmd_driver.sv
// Purpose  : command-side driver for a 4-bit combinational calculator (add/sub/and/or).
// Latency  : command accepted at edge N, result captured at edge N+1, rsp_valid high until consumed.
// Backpress: cmd_ready drops from accept until the response is taken; rsp_valid holds until rsp_ready.
//
// Ports
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_a, cmd_b, cmd_op, cmd_chain   operands, op code, "use previous result as A"
//   calc_a, calc_b, calc_op           registered operands/op driven into the calculator
//   calc_result                       combinational result returned by the calculator
//   rsp_valid/rsp_ready               response handshake
//   rsp_result, rsp_zero              captured result and its zero flag
//   op_count                          number of responses consumed (wraps)
module calc_cmd_driver #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    output logic [1:0]       calc_op,
    input  logic [WIDTH-1:0] calc_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_capture;
    logic             w_rsp_done;
    logic             w_cmd_ready;
    logic [WIDTH-1:0] w_op_a;

    logic [WIDTH-1:0] r_calc_a;
    logic [WIDTH-1:0] r_calc_b;
    logic [1:0]       r_calc_op;
    logic [WIDTH-1:0] r_last_result;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic [CNT_W-1:0] r_op_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobes; cmd_ready depends on state only so there is
    // no combinational path from rsp_ready back to the command source.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        w_cmd_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture    = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Chained commands take operand A from the previous captured result.
    assign w_op_a = cmd_chain ? r_last_result : cmd_a;

    // Calculator operand registers: loaded on accept, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calc_a  <= '0;
            r_calc_b  <= '0;
            r_calc_op <= 2'b00;
        end else if (w_accept) begin
            r_calc_a  <= w_op_a;
            r_calc_b  <= cmd_b;
            r_calc_op <= cmd_op;
        end
    end

    // Result capture happens only in EXEC, so calc_result activity at any
    // other time never reaches the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_last_result <= '0;
        end else if (w_capture) begin
            r_rsp_result  <= calc_result;
            r_rsp_zero    <= (calc_result == '0);
            r_last_result <= calc_result;
        end
    end

    // Response valid and consumed-operation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_capture) begin
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_rsp_done) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign calc_a     = r_calc_a;
    assign calc_b     = r_calc_b;
    assign calc_op    = r_calc_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_calc_cmd_driver.sv
module tb_calc_cmd_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_op;
    logic       cmd_chain;
    logic [3:0] calc_a;
    logic [3:0] calc_b;
    logic [1:0] calc_op;
    logic [3:0] calc_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_zero;
    logic [7:0] op_count;

    calc_cmd_driver #(.WIDTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .cmd_chain  (cmd_chain),
        .calc_a     (calc_a),
        .calc_b     (calc_b),
        .calc_op    (calc_op),
        .calc_result(calc_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .op_count   (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference calculator: results modulo 16
    function automatic logic [3:0] calc_f(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    always_comb calc_result = calc_f(calc_a, calc_b, calc_op);

    typedef struct packed {
        logic [3:0] res;
        logic       zero;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         prev_cyc = -1;
    int         rsp_seen = 0;
    bit         interval_on = 1'b0;
    logic [3:0] ref_last = 4'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a response is consumed on the next rising edge whenever
    // valid and ready are both high in the preceding low phase.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got result %0h with no command outstanding", rsp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            end
            if (interval_on) begin
                if (prev_cyc >= 0) chk("rsp_interval", 32'(cyc - prev_cyc), 32'd3);
                prev_cyc = cyc;
                rsp_seen++;
            end
        end
    end

    // Issue one command; the expected response is queued once it is accepted.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic chain, input logic [3:0] exp_res, input bit push);
        bit got;
        got       = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, expected 1 within 50 cycles");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            if (push) begin
                exp_q.push_back({exp_res, (exp_res == 4'h0)});
                ref_last = exp_res;
            end
        end
    endtask

    task automatic wait_rsp_valid();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_total++;
            $display("FAIL rsp_valid_timeout: rsp_valid stayed 0, expected 1 within 20 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a, b, e;
        logic [1:0] op;
        logic       ch;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_op    = 2'b00;
        cmd_chain = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_calc_a", 32'(calc_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 3 + 5 = 8, with operand registers and latency
        send(4'h3, 4'h5, 2'b00, 1'b0, 4'h8, 1'b1);
        chk("t1_calc_a", 32'(calc_a), 32'd3);
        chk("t1_calc_b", 32'(calc_b), 32'd5);
        chk("t1_calc_op", 32'(calc_op), 32'd0);
        chk("t1_cmd_ready_exec", 32'(cmd_ready), 32'd0);
        chk("t1_rsp_valid_exec", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_rsp_valid_resp", 32'(rsp_valid), 32'd1);
        drain();

        // 2: 2 - 5 wraps to D
        send(4'h2, 4'h5, 2'b01, 1'b0, 4'hD, 1'b1);
        drain();

        // 3: 7 + 9 wraps to 0, then chained OR: 0 | 3 = 3
        send(4'h7, 4'h9, 2'b00, 1'b0, 4'h0, 1'b1);
        send(4'hF, 4'h3, 2'b11, 1'b1, 4'h3, 1'b1);
        chk("t3_chain_calc_a", 32'(calc_a), 32'd0);
        chk("t3_chain_calc_op", 32'(calc_op), 32'd3);
        drain();
        chk("t3_op_count", 32'(op_count), 32'd4);

        // 4: response backpressure, held command not accepted
        rsp_ready = 1'b0;
        send(4'h4, 4'h6, 2'b10, 1'b0, 4'h4, 1'b1);
        wait_rsp_valid();
        cmd_a     = 4'h9;
        cmd_b     = 4'h6;
        cmd_op    = 2'b11;
        cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_rsp_result", 32'(rsp_result), 32'd4);
            chk("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("t4_hold_calc_a", 32'(calc_a), 32'd4);
            chk("t4_hold_op_count", 32'(op_count), 32'd4);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_op_count_inc", 32'(op_count), 32'd5);
        chk("t4_rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("t4_cmd_ready_back", 32'(cmd_ready), 32'd1);
        send(4'h9, 4'h6, 2'b11, 1'b0, 4'hF, 1'b1);
        drain();
        chk("t4_op_count_final", 32'(op_count), 32'd6);

        // 5: reset asserted during EXEC discards the operation
        send(4'h1, 4'h1, 2'b00, 1'b0, 4'h2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_calc_a", 32'(calc_a), 32'd0);
        chk("t5_calc_b", 32'(calc_b), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rsp_result", 32'(rsp_result), 32'd0);
        chk("t5_op_count", 32'(op_count), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        ref_last = 4'h0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_rsp_after", 32'(rsp_valid), 32'd0);
        chk("t5_op_count_after", 32'(op_count), 32'd0);

        // 6: 256 back-to-back ops against the reference model
        prev_cyc    = -1;
        rsp_seen    = 0;
        interval_on = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a  = 4'(i);
            b  = 4'(i * 7 + 3);
            op = 2'(i >> 2);
            ch = ((i % 5) == 4);
            e  = calc_f(ch ? ref_last : a, b, op);
            send(a, b, op, ch, e, 1'b1);
        end
        drain();
        interval_on = 1'b0;
        chk("t6_rsp_count", 32'(rsp_seen), 32'd256);
        chk("t6_op_count_wrap", 32'(op_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
